// File: rtl/max7219_cmd_sched_if.sv
// Word stream from the MAX7219 command scheduler to the word serializer.
//
// Signals:
//   tx_valid  a word is presented (master -> slave)
//   tx_ready  serializer takes the word when tx_valid && tx_ready (slave -> master)
//   tx_addr   MAX7219 register address (master -> slave)
//   tx_data   MAX7219 register data (master -> slave)
interface max7219_cmd_sched_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_addr;
    logic [7:0] tx_data;

    modport master (output tx_valid, output tx_addr, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_addr, input tx_data, output tx_ready);
endinterface

// File: rtl/max7219_cmd_sched.sv
// Command scheduler for the MAX7219 8-digit display driver.
// After reset it issues the five-word power-up configuration. It then
// arbitrates shutdown, intensity and per-digit buffer updates, in that fixed
// priority, onto one address/data word stream for the serializer.
//
// Ports:
//   clk, reset_n        clock; asynchronous active-low reset
//   digit_we/idx/val    digit buffer write (one cycle per write)
//   intensity_req/val   intensity update strobe and value
//   shutdown_req/val    shutdown update strobe and value (1 = shut down)
//   tx                  word stream to the serializer (master side)
//   init_done           sticky once the power-up sequence has been accepted
//   busy                scheduler not idle, or any update still pending
module max7219_cmd_sched #(
    parameter int         NUM_DIGITS     = 8,
    parameter logic [7:0] SCAN_LIMIT     = 8'd7,
    parameter logic [3:0] INIT_INTENSITY = 4'hF,
    parameter logic [7:0] DECODE_MODE    = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       digit_we,
    input  logic [2:0]                 digit_idx,
    input  logic [7:0]                 digit_val,
    input  logic                       intensity_req,
    input  logic [3:0]                 intensity_val,
    input  logic                       shutdown_req,
    input  logic                       shutdown_val,
    max7219_cmd_sched_if.master        tx,
    output logic                       init_done,
    output logic                       busy
);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_SEND} state_t;

    state_t     state_reg;
    logic [2:0] init_cnt_reg;
    logic       tx_valid_reg;
    logic [7:0] tx_addr_reg;
    logic [7:0] tx_data_reg;
    logic       init_done_reg;

    logic       sd_pend_reg;
    logic       sd_val_reg;
    logic       int_pend_reg;
    logic [3:0] int_val_reg;

    logic [NUM_DIGITS-1:0] dirty_reg;
    logic [7:0]            buf_val [NUM_DIGITS];

    logic       in_idle;
    logic       load_sd;
    logic       load_int;
    logic       load_dig;
    logic [2:0] dig_sel;
    logic [7:0] dig_data;

    // Power-up configuration: display test off, normal operation, scan
    // limit, intensity, decode mode.
    function automatic logic [15:0] init_word(input logic [2:0] idx);
        case (idx)
            3'd0:    init_word = 16'h0F00;
            3'd1:    init_word = 16'h0C01;
            3'd2:    init_word = {8'h0B, SCAN_LIMIT};
            3'd3:    init_word = {8'h0A, 4'h0, INIT_INTENSITY};
            3'd4:    init_word = {8'h09, DECODE_MODE};
            default: init_word = 16'h0F00;
        endcase
    endfunction

    // Fixed-priority selection; only evaluated as a load while idle.
    assign in_idle  = (state_reg == ST_IDLE);
    assign load_sd  = in_idle && sd_pend_reg;
    assign load_int = in_idle && !sd_pend_reg && int_pend_reg;
    assign load_dig = in_idle && !sd_pend_reg && !int_pend_reg && (|dirty_reg);

    // Lowest-index dirty digit: scan downward so the lowest match wins.
    always_comb begin
        dig_sel  = 3'd0;
        dig_data = 8'h00;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (dirty_reg[i]) begin
                dig_sel  = 3'(i);
                dig_data = buf_val[i];
            end
        end
    end

    // Digit storage. A write in the same edge as the load that clears the
    // dirty bit keeps the bit set, so the newer value is sent afterwards.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [7:0] val_reg;
            logic       dirty_bit_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    val_reg       <= 8'h00;
                    dirty_bit_reg <= 1'b1;
                end else if (digit_we && (digit_idx == 3'(gi))) begin
                    val_reg       <= digit_val;
                    dirty_bit_reg <= 1'b1;
                end else if (load_dig && (dig_sel == 3'(gi))) begin
                    dirty_bit_reg <= 1'b0;
                end
            end

            assign buf_val[gi]   = val_reg;
            assign dirty_reg[gi] = dirty_bit_reg;
        end
    endgenerate

    // One pending slot per class; a new strobe beats the clear from a load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sd_pend_reg  <= 1'b0;
            sd_val_reg   <= 1'b0;
            int_pend_reg <= 1'b0;
            int_val_reg  <= 4'h0;
        end else begin
            if (shutdown_req) begin
                sd_pend_reg <= 1'b1;
                sd_val_reg  <= shutdown_val;
            end else if (load_sd) begin
                sd_pend_reg <= 1'b0;
            end

            if (intensity_req) begin
                int_pend_reg <= 1'b1;
                int_val_reg  <= intensity_val;
            end else if (load_int) begin
                int_pend_reg <= 1'b0;
            end
        end
    end

    // Main sequencer. Init words are chained back to back on accept; in
    // steady state an IDLE cycle separates each accept from the next load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_INIT;
            init_cnt_reg  <= 3'd0;
            tx_valid_reg  <= 1'b0;
            tx_addr_reg   <= 8'h00;
            tx_data_reg   <= 8'h00;
            init_done_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    if (!tx_valid_reg) begin
                        {tx_addr_reg, tx_data_reg} <= init_word(init_cnt_reg);
                        tx_valid_reg               <= 1'b1;
                    end else if (tx.tx_ready) begin
                        if (init_cnt_reg == 3'd4) begin
                            tx_valid_reg  <= 1'b0;
                            init_done_reg <= 1'b1;
                            init_cnt_reg  <= 3'd0;
                            state_reg     <= ST_IDLE;
                        end else begin
                            init_cnt_reg               <= init_cnt_reg + 3'd1;
                            {tx_addr_reg, tx_data_reg} <= init_word(init_cnt_reg + 3'd1);
                        end
                    end
                end
                ST_IDLE: begin
                    if (load_sd) begin
                        tx_addr_reg  <= 8'h0C;
                        tx_data_reg  <= {7'b0, ~sd_val_reg};
                        tx_valid_reg <= 1'b1;
                        state_reg    <= ST_SEND;
                    end else if (load_int) begin
                        tx_addr_reg  <= 8'h0A;
                        tx_data_reg  <= {4'h0, int_val_reg};
                        tx_valid_reg <= 1'b1;
                        state_reg    <= ST_SEND;
                    end else if (load_dig) begin
                        tx_addr_reg  <= 8'({5'b0, dig_sel}) + 8'd1;
                        tx_data_reg  <= dig_data;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx.tx_ready) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg    <= ST_INIT;
                    tx_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign tx.tx_valid = tx_valid_reg;
    assign tx.tx_addr  = tx_addr_reg;
    assign tx.tx_data  = tx_data_reg;
    assign init_done   = init_done_reg;
    assign busy        = (state_reg != ST_IDLE) || sd_pend_reg || int_pend_reg || (|dirty_reg);

endmodule

// File: tb/tb_max7219_cmd_sched.sv
// Directed self-checking bench for max7219_cmd_sched. A second instance with
// four digits checks that out-of-range digit writes produce no word.
module tb_max7219_cmd_sched;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       digit_we;
    logic [2:0] digit_idx;
    logic [7:0] digit_val;
    logic       intensity_req;
    logic [3:0] intensity_val;
    logic       shutdown_req;
    logic       shutdown_val;
    logic       init_done, busy;
    logic       init_done4, busy4;

    int n_checks = 0;
    int n_fail   = 0;
    int n_good4  = 0;
    int n_bad4   = 0;

    logic [15:0] q[$];

    max7219_cmd_sched_if tx_if ();
    max7219_cmd_sched_if tx_if4 ();

    always #5 clk = ~clk;

    max7219_cmd_sched dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .digit_we      (digit_we),
        .digit_idx     (digit_idx),
        .digit_val     (digit_val),
        .intensity_req (intensity_req),
        .intensity_val (intensity_val),
        .shutdown_req  (shutdown_req),
        .shutdown_val  (shutdown_val),
        .tx            (tx_if.master),
        .init_done     (init_done),
        .busy          (busy)
    );

    max7219_cmd_sched #(.NUM_DIGITS(4)) dut4 (
        .clk           (clk),
        .reset_n       (reset_n),
        .digit_we      (digit_we),
        .digit_idx     (digit_idx),
        .digit_val     (digit_val),
        .intensity_req (intensity_req),
        .intensity_val (intensity_val),
        .shutdown_req  (shutdown_req),
        .shutdown_val  (shutdown_val),
        .tx            (tx_if4.master),
        .init_done     (init_done4),
        .busy          (busy4)
    );

    assign tx_if4.tx_ready = 1'b1;

    // Accepted words are recorded mid-cycle, where valid/ready are stable.
    always @(negedge clk) begin
        if (reset_n && tx_if.tx_valid && tx_if.tx_ready)
            q.push_back({tx_if.tx_addr, tx_if.tx_data});
        if (reset_n && tx_if4.tx_valid) begin
            if (tx_if4.tx_addr >= 8'd1 && tx_if4.tx_addr <= 8'd4) n_good4++;
            if (tx_if4.tx_addr >= 8'd5 && tx_if4.tx_addr <= 8'd8) n_bad4++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] exp);
        logic [16:0] obs;
        if (q.size() > 0) obs = {1'b0, q.pop_front()};
        else              obs = 17'h10000;
        $display("txn %s: addr/data 0x%04h expected 0x%04h", tag, obs[15:0], exp);
        check(tag, 32'(obs), 32'({1'b0, exp}));
    endtask

    task automatic write_digit(input logic [2:0] idx, input logic [7:0] val);
        digit_we  = 1'b1;
        digit_idx = idx;
        digit_val = val;
        step();
        digit_we  = 1'b0;
    endtask

    // Called just after reset release with an empty queue and tx_ready=1.
    task automatic powerup_run(input string tag);
        logic [15:0] exp_w [13];
        exp_w = '{16'h0F00, 16'h0C01, 16'h0B07, 16'h0A0F, 16'h09FF,
                  16'h0100, 16'h0200, 16'h0300, 16'h0400,
                  16'h0500, 16'h0600, 16'h0700, 16'h0800};
        step();
        check({tag, " first valid"}, 32'(tx_if.tx_valid), 32'd1);
        check({tag, " first word"}, 32'({tx_if.tx_addr, tx_if.tx_data}), 32'h0F00);
        for (int k = 0; k < 40; k++) begin
            check({tag, " init_done"}, 32'(init_done), 32'(q.size() >= 5));
            check({tag, " busy"}, 32'(busy), 32'(q.size() < 13));
            if (q.size() >= 13) break;
            step();
        end
        for (int i = 0; i < 13; i++)
            pop_expect($sformatf("%s word %0d", tag, i), exp_w[i]);
    endtask

    initial begin
        logic [15:0] held;
        int          bad;

        reset_n         = 1'b0;
        digit_we        = 1'b0;
        digit_idx       = 3'd0;
        digit_val       = 8'h00;
        intensity_req   = 1'b0;
        intensity_val   = 4'h0;
        shutdown_req    = 1'b0;
        shutdown_val    = 1'b0;
        tx_if.tx_ready  = 1'b1;

        repeat (3) step();
        check("rst tx_valid",  32'(tx_if.tx_valid), 32'd0);
        check("rst tx_addr",   32'(tx_if.tx_addr),  32'h00);
        check("rst tx_data",   32'(tx_if.tx_data),  32'h00);
        check("rst init_done", 32'(init_done),      32'd0);
        check("rst busy",      32'(busy),           32'd1);

        reset_n = 1'b1;
        powerup_run("pwr");

        repeat (5) step();
        check("idle no words", 32'(q.size()), 32'd0);
        check("idle busy",     32'(busy),     32'd0);

        // Latency: write sampled at edge N, word valid after edge N+1.
        write_digit(3'd3, 8'h85);
        check("lat N valid",   32'(tx_if.tx_valid), 32'd0);
        step();
        check("lat N+1 valid", 32'(tx_if.tx_valid), 32'd1);
        check("lat N+1 word",  32'({tx_if.tx_addr, tx_if.tx_data}), 32'h0485);
        repeat (8) step();
        pop_expect("lat word", 16'h0485);
        check("lat one word", 32'(q.size()), 32'd0);

        // Simultaneous requests from all three classes.
        shutdown_req  = 1'b1; shutdown_val  = 1'b1;
        intensity_req = 1'b1; intensity_val = 4'h5;
        digit_we = 1'b1; digit_idx = 3'd0; digit_val = 8'h12;
        step();
        shutdown_req = 1'b0; intensity_req = 1'b0; digit_we = 1'b0;
        repeat (10) step();
        pop_expect("prio shutdown",  16'h0C00);
        pop_expect("prio intensity", 16'h0A05);
        pop_expect("prio digit0",    16'h0112);
        check("prio count", 32'(q.size()), 32'd0);

        // Back-pressure: word must hold for 20 cycles, then be taken once.
        tx_if.tx_ready = 1'b0;
        write_digit(3'd5, 8'h55);
        step();
        check("stall valid", 32'(tx_if.tx_valid), 32'd1);
        check("stall word",  32'({tx_if.tx_addr, tx_if.tx_data}), 32'h0655);
        held = {tx_if.tx_addr, tx_if.tx_data};
        bad  = 0;
        repeat (20) begin
            step();
            if (!tx_if.tx_valid || ({tx_if.tx_addr, tx_if.tx_data} != held)) bad++;
        end
        check("stall hold",      32'(bad),      32'd0);
        check("stall no accept", 32'(q.size()), 32'd0);
        tx_if.tx_ready = 1'b1;
        step();
        check("stall release valid", 32'(tx_if.tx_valid), 32'd0);
        repeat (4) step();
        pop_expect("stall word accepted", 16'h0655);
        check("stall once", 32'(q.size()), 32'd0);

        // Rewrite of a digit whose word is in flight is resent afterwards.
        tx_if.tx_ready = 1'b0;
        write_digit(3'd2, 8'h11);
        step();
        check("rewrite first word", 32'({tx_if.tx_addr, tx_if.tx_data}), 32'h0311);
        write_digit(3'd2, 8'h22);
        check("rewrite in-flight data", 32'(tx_if.tx_data), 32'h11);
        tx_if.tx_ready = 1'b1;
        repeat (8) step();
        pop_expect("rewrite old", 16'h0311);
        pop_expect("rewrite new", 16'h0322);
        write_digit(3'd6, 8'h66);
        repeat (5) step();
        pop_expect("digit6", 16'h0766);
        check("rewrite count", 32'(q.size()), 32'd0);
        check("narrow dut out-of-range words", 32'(n_bad4),  32'd0);
        check("narrow dut in-range words",     32'(n_good4), 32'd8);

        // Reset pulse while the third init word is presented.
        check("pre-pulse init_done", 32'(init_done), 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        step();
        step();
        check("pulse 3rd word", 32'({tx_if.tx_addr, tx_if.tx_data}), 32'h0B07);
        reset_n = 1'b0;
        q.delete();
        #1;
        check("pulse tx_valid",  32'(tx_if.tx_valid), 32'd0);
        check("pulse tx_addr",   32'(tx_if.tx_addr),  32'h00);
        check("pulse tx_data",   32'(tx_if.tx_data),  32'h00);
        check("pulse init_done", 32'(init_done),      32'd0);
        check("pulse busy",      32'(busy),           32'd1);
        step();
        reset_n = 1'b1;
        powerup_run("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
